// File: rtl/ppu_vga_scanout.sv
// Frame-buffer read end and 640x480 VGA timing generator: fetches the 256x240 NES
// picture doubled to 512x480, centred, with a two-tick pipeline to the DAC outputs.
module ppu_vga_scanout #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned X_OFFSET     = 64,
  parameter logic [7:0]  BORDER_INDEX = 8'h0F
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] fb_row,
  output logic [8:0] fb_col,
  output logic       fb_rd_en,
  input  logic [7:0] fb_data,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_de,
  output logic [7:0] vga_pixel,
  output logic       frame_start,
  output logic       vblank,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_OFF  = 10'(X_OFFSET);
  localparam logic [9:0] PIC_W  = 10'd512;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             tick, h_wrap, v_wrap;
  logic [9:0]       h_off;
  logic             active, pic, hs, vs;

  logic             active_p1_q, pic_p1_q, hs_p1_q, vs_p1_q;
  logic [8:0]       fb_row_q, fb_col_q;
  logic             fb_rd_en_q;

  logic             hsync_p2_q, vsync_p2_q, de_p2_q;
  logic [7:0]       pixel_p2_q;

  logic             frame_start_q, vblank_q;
  logic [7:0]       frame_count_q;

  function automatic logic [7:0] pick_pixel(input logic pic1, input logic active1,
                                            input logic [7:0] data);
    if (pic1)         return data;
    else if (active1) return BORDER_INDEX;
    else              return 8'h00;
  endfunction

  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Columns left of X_OFFSET wrap to large values, so one compare bounds the picture.
  assign h_off  = h_q - X_OFF;
  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign pic    = active && (h_off < PIC_W);
  assign hs     = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs     = (v_q >= VS_BEG) && (v_q < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      vblank_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= tick && h_wrap && v_wrap;
      if (tick) begin
        vblank_q <= (v_q >= V_ACT);
        if (h_wrap && v_wrap) frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  // Stage 1: frame-buffer address and read strobe, region flags
  always_ff @(posedge clk) begin
    if (rst) begin
      active_p1_q <= 1'b0;
      pic_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
      fb_row_q    <= '0;
      fb_col_q    <= '0;
      fb_rd_en_q  <= 1'b0;
    end else begin
      fb_rd_en_q <= tick && pic;
      if (tick) begin
        active_p1_q <= active;
        pic_p1_q    <= pic;
        hs_p1_q     <= hs;
        vs_p1_q     <= vs;
        if (pic) begin
          fb_col_q <= h_off[9:1];
          fb_row_q <= v_q[9:1];
        end
      end
    end
  end

  // Stage 2: sync, data-enable and pixel toward the DAC
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p2_q <= 1'b1;
      vsync_p2_q <= 1'b1;
      de_p2_q    <= 1'b0;
      pixel_p2_q <= 8'h00;
    end else if (tick) begin
      hsync_p2_q <= ~hs_p1_q;
      vsync_p2_q <= ~vs_p1_q;
      de_p2_q    <= active_p1_q;
      pixel_p2_q <= pick_pixel(pic_p1_q, active_p1_q, fb_data);
    end
  end

  assign fb_row      = fb_row_q;
  assign fb_col      = fb_col_q;
  assign fb_rd_en    = fb_rd_en_q;
  assign vga_hsync   = hsync_p2_q;
  assign vga_vsync   = vsync_p2_q;
  assign vga_de      = de_p2_q;
  assign vga_pixel   = pixel_p2_q;
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ppu_vga_scanout.sv
// Directed bench: a short-frame scanout instance for timing, mapping and data path,
// plus a tiny-frame instance to reach the frame_count wrap quickly.
module tb_ppu_vga_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] fb_row, fb_col;
  logic       fb_rd_en;
  logic [7:0] fb_data = 8'h00;
  logic       vga_hsync, vga_vsync, vga_de, frame_start, vblank;
  logic [7:0] vga_pixel, frame_count;

  logic [8:0] fb_row_b, fb_col_b;
  logic       fb_rd_en_b;
  logic [7:0] fb_data_b = 8'h00;
  logic       vga_hsync_b, vga_vsync_b, vga_de_b, frame_start_b, vblank_b;
  logic [7:0] vga_pixel_b, frame_count_b;

  // 800 x 11 frame, 2 clk per tick: line = 1600 clk, frame = 17600 clk
  ppu_vga_scanout #(
    .CLK_DIV(2), .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .fb_row(fb_row), .fb_col(fb_col), .fb_rd_en(fb_rd_en),
    .fb_data(fb_data), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_pixel(vga_pixel), .frame_start(frame_start), .vblank(vblank),
    .frame_count(frame_count)
  );

  // 7 x 5 frame, 2 clk per tick: frame = 70 clk
  ppu_vga_scanout #(
    .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .X_OFFSET(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .fb_row(fb_row_b), .fb_col(fb_col_b), .fb_rd_en(fb_rd_en_b),
    .fb_data(fb_data_b), .vga_hsync(vga_hsync_b), .vga_vsync(vga_vsync_b),
    .vga_de(vga_de_b), .vga_pixel(vga_pixel_b), .frame_start(frame_start_b),
    .vblank(vblank_b), .frame_count(frame_count_b)
  );

  // Frame-buffer model: data = column, one clk after the strobe
  always_ff @(posedge clk) begin
    if (fb_rd_en)   fb_data   <= fb_col[7:0];
    if (fb_rd_en_b) fb_data_b <= fb_col_b[7:0];
  end

  int total = 0;
  int bad   = 0;
  int edges = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (edges < n) begin
      @(posedge clk);
      edges++;
    end
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hsync"}, vga_hsync, 1);
    chk({tag, "_vsync"}, vga_vsync, 1);
    chk({tag, "_de"}, vga_de, 0);
    chk({tag, "_pixel"}, vga_pixel, 0);
    chk({tag, "_rd_en"}, fb_rd_en, 0);
    chk({tag, "_row"}, fb_row, 0);
    chk({tag, "_col"}, fb_col, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_vblank"}, vblank, 0);
    chk({tag, "_fcount"}, frame_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int early_rd;
    int hs_low;
    int de_high;
    int vs_low;
    logic vb8, vb10;
    early_rd = 0; hs_low = 0; de_high = 0; vs_low = 0;
    vb8 = 1'b0; vb10 = 1'b0;

    rst = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_b_fcount", frame_count_b, 0);
    rst = 1'b0; rst_b = 1'b0;
    edges = 0;

    // No read before the h=64 tick of line 0 (tick 65 = edge 130)
    while (edges < 129) begin
      @(posedge clk);
      edges++;
      #1;
      if (fb_rd_en) early_rd++;
    end
    chk("no_early_rd", early_rd, 0);
    goto(130);
    chk("first_rd_en", fb_rd_en, 1);
    chk("first_col", fb_col, 0);
    chk("first_row", fb_row, 0);
    goto(131);
    chk("rd_pulse_1clk", fb_rd_en, 0);

    // One full line period of line 1
    goto(1604);
    while (edges < 3204) begin
      @(posedge clk);
      edges++;
      #1;
      if (!vga_hsync) hs_low++;
      if (vga_de) de_high++;
    end
    chk("hsync_low_clk", hs_low, 192);
    chk("de_high_clk", de_high, 1280);

    // Line v=7: outputs for position p appear after edge 2*(p+2), address after 2*(p+1)
    goto(11204);
    chk("pix_h0_border", vga_pixel, 8'h0F);
    chk("de_h0", vga_de, 1);
    goto(11328);
    chk("rd_h63_none", fb_rd_en, 0);
    chk("col_hold_h63", fb_col, 255);
    goto(11330);
    chk("rd_h64", fb_rd_en, 1);
    chk("row_h64", fb_row, 3);
    chk("col_h64", fb_col, 0);
    chk("pix_h63_border", vga_pixel, 8'h0F);
    goto(11332);
    chk("col_h65", fb_col, 0);
    chk("pix_h64", vga_pixel, 0);
    goto(11334);
    chk("col_h66", fb_col, 1);
    chk("pix_h65", vga_pixel, 0);
    goto(11336);
    chk("pix_h66", vga_pixel, 1);
    goto(11800);
    chk("vblank_v7", vblank, 0);
    goto(12352);
    chk("rd_h575", fb_rd_en, 1);
    chk("col_h575", fb_col, 255);
    goto(12354);
    chk("pix_h575", vga_pixel, 255);
    chk("rd_h576_none", fb_rd_en, 0);
    chk("col_hold_h576", fb_col, 255);
    goto(12356);
    chk("pix_h576_border", vga_pixel, 8'h0F);
    goto(12482);
    chk("de_h639", vga_de, 1);
    chk("pix_h639_border", vga_pixel, 8'h0F);
    goto(12484);
    chk("de_h640", vga_de, 0);
    chk("pix_h640_blank", vga_pixel, 0);
    goto(12514);
    chk("hsync_h655", vga_hsync, 1);
    goto(12516);
    chk("hsync_h656", vga_hsync, 0);
    goto(12706);
    chk("hsync_h751", vga_hsync, 0);
    goto(12708);
    chk("hsync_h752", vga_hsync, 1);

    // Vertical blanking lines 8..10
    while (edges < 17594) begin
      @(posedge clk);
      edges++;
      #1;
      if (!vga_vsync) vs_low++;
      if (edges == 13400) vb8 = vblank;
      if (edges == 16600) vb10 = vblank;
    end
    chk("vsync_low_clk", vs_low, 1600);
    chk("vblank_v8", vb8, 1);
    chk("vblank_v10", vb10, 1);

    goto(17598);
    chk("fs_before_wrap", frame_start, 0);
    goto(17600);
    chk("fs_wrap", frame_start, 1);
    chk("fcount_1", frame_count, 1);
    goto(17601);
    chk("fs_1clk", frame_start, 0);

    goto(17850);
    chk("b_fcount_255", frame_count_b, 255);
    goto(17919);
    chk("b_fcount_255_hold", frame_count_b, 255);
    goto(17920);
    chk("b_fcount_wrap0", frame_count_b, 0);
    chk("b_fs_wrap", frame_start_b, 1);

    // Frame 2, v=3, h=300: mid-picture reset
    goto(23000);
    chk("mid_rd_en", fb_rd_en, 1);
    chk("mid_de", vga_de, 1);
    chk("mid_pix_h298", vga_pixel, 117);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("midrst");
    rst = 1'b0;
    edges = 0;
    goto(128);
    chk("post_rst_no_rd", fb_rd_en, 0);
    goto(130);
    chk("post_rst_rd", fb_rd_en, 1);
    chk("post_rst_col", fb_col, 0);
    chk("post_rst_row", fb_row, 0);
    chk("post_rst_fcount", frame_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
